fir_17_filter: RTL and testbench

- 17-tap, linear-phase, low-pass FIR filter.
- Takes an 8-bit signed sample stream with a per-sample valid strobe and produces a 24-bit signed filtered result.
- Sits in the sample datapath between the sample source and downstream processing or capture logic.
- Coefficients are fixed constants; there is no runtime coefficient loading.

---
 rtl/fir_17_filter.sv | 93 +++++++++
 tb/tb_fir_17_filter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_17_filter.sv
`default_nettype none
// ============================================================================
//  Module      : fir_17_filter
//  Description : 17-tap linear-phase low-pass FIR. 8-bit signed samples in,
//                24-bit signed full-precision result out. A valid-gated delay
//                line feeds a registered product stage and then a registered
//                adder-tree stage (2-cycle latency from sample acceptance).
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_17_filter #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 24,
    parameter int TAPS   = 17
) (
    input  logic                     clk,
    input  logic                     rst,      // asynchronous, active-low
    input  logic signed [DATA_W-1:0] data_i,
    input  logic                     valid_i,
    output logic signed [OUT_W-1:0]  data_o
);

    localparam int c_prod_w = DATA_W + COEF_W;

    // Fixed symmetric coefficient set; tap 0 multiplies the newest sample.
    function automatic logic signed [COEF_W-1:0] f_coef(input int k);
        int v;
        case (k)
            0, 16:   v = -1;
            1, 15:   v = -3;
            2, 14:   v = -4;
            3, 13:   v = 0;
            4, 12:   v = 9;
            5, 11:   v = 22;
            6, 10:   v = 35;
            7, 9:    v = 45;
            8:       v = 49;
            default: v = 0;
        endcase
        return COEF_W'(v);
    endfunction

    logic signed [DATA_W-1:0]   r_x [TAPS];
    logic signed [c_prod_w-1:0] r_p [TAPS];
    logic signed [OUT_W-1:0]    w_sum;

    // Delay line: shifts in a new sample only on valid cycles, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (valid_i) begin
            r_x[0] <= data_i;
            for (int k = 1; k < TAPS; k++) begin
                r_x[k] <= r_x[k-1];
            end
        end
    end

    // Product stage: every tap registered every cycle, independent of valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_p[k] <= '0;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                r_p[k] <= c_prod_w'(f_coef(k)) * c_prod_w'(r_x[k]);
            end
        end
    end

    // Sum of all products, sign-extended; the true range fits in 17 bits,
    // so accumulating at output width can never overflow.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_sum = w_sum + OUT_W'(r_p[k]);
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o <= '0;
        end else begin
            data_o <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_17_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_17_filter
//  Description : Self-checking bench for fir_17_filter: table-driven impulse
//                vectors, hand-written corner sequences and random stimulus
//                checked against a convolution model over the sample history.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_17_filter;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [7:0]  data_i;
    logic               valid_i;
    logic signed [23:0] data_o;

    always #5 clk = ~clk;

    fir_17_filter #(
        .DATA_W (8),
        .COEF_W (8),
        .OUT_W  (24),
        .TAPS   (17)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .data_o  (data_o)
    );

    int total = 0;
    int bad   = 0;
    int e;

    int h [17] = '{-1, -3, -4, 0, 9, 22, 35, 45, 49, 45, 35, 22, 9, 0, -4, -3, -1};

    // Reference model: accepted samples newest-first, and the filter value of
    // the history one and two edges back (output lags the history by 2 edges).
    int hist [$];
    int yq0;
    int yq1;

    typedef struct {
        int d;
        int v;
        int exp;
    } vec_t;

    vec_t tbl [21];

    function automatic int conv();
        int s;
        s = 0;
        for (int k = 0; k < hist.size(); k++) begin
            s += h[k] * hist[k];
        end
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        yq0 = 0;
        yq1 = 0;
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 ns later.
    task automatic tick(input int d, input int v, output int exp);
        data_i  = 8'(d);
        valid_i = (v != 0);
        @(posedge clk);
        exp = yq1;
        yq1 = yq0;
        if (v != 0) begin
            hist.push_front(d);
            if (hist.size() > 17) void'(hist.pop_back());
        end
        yq0 = conv();
        #1;
        check("model", int'(data_o), exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit reached;

        rst     = 1'b0;
        data_i  = '0;
        valid_i = 1'b0;
        model_clear();

        // Reset held: random valid data must never reach the output.
        repeat (6) begin
            data_i  = 8'($urandom);
            valid_i = 1'b1;
            @(posedge clk);
            #1;
            check("reset_hold", int'(data_o), 0);
        end
        #2 rst = 1'b1;

        repeat (5) begin
            tick(0, 1, e);
            check("post_reset_zero", int'(data_o), 0);
        end

        // Impulse response table: first coefficient two edges after the impulse.
        for (int i = 0; i < 21; i++) begin
            tbl[i].d   = (i == 0) ? 1 : 0;
            tbl[i].v   = 1;
            tbl[i].exp = (i >= 2 && i < 19) ? h[i-2] : 0;
        end
        for (int i = 0; i < 21; i++) begin
            tick(tbl[i].d, tbl[i].v, e);
            check("impulse", int'(data_o), tbl[i].exp);
        end

        // Step responses.
        repeat (19) tick(1, 1, e);
        check("step_pos", int'(data_o), 255);
        repeat (19) tick(-128, 1, e);
        check("step_neg", int'(data_o), -32640);

        // Extremes: positive taps see 127, negative taps see -128
        // -> 271*127 + 16*128 = 36465. Oldest sample first.
        for (int k = 16; k >= 0; k--) begin
            tick((h[k] > 0) ? 127 : ((h[k] < 0) ? -128 : 0), 1, e);
        end
        repeat (2) tick(0, 0, e);
        check("extreme_pos", int'(data_o), 36465);

        // Opposite signs -> -(271*128) - 16*127 = -36720.
        for (int k = 16; k >= 0; k--) begin
            tick((h[k] > 0) ? -128 : ((h[k] < 0) ? 127 : 0), 1, e);
        end
        repeat (2) tick(0, 0, e);
        check("extreme_neg", int'(data_o), -36720);
        check("extreme_sign_ext", int'(data_o[23:17]), 127);

        // Valid gating: impulse with valid toggling, then a 5-cycle gap.
        repeat (19) tick(0, 1, e);
        tick(1, 1, e);
        tick(0, 0, e);
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, e);
            tick(0, 0, e);
        end
        check("gated_hold", int'(data_o), h[5]);
        repeat (5) begin
            tick(0, 0, e);
            check("gap_frozen", int'(data_o), h[6]);
        end
        for (int i = 0; i < 12; i++) begin
            tick(0, 1, e);
            tick(0, 0, e);
        end
        check("gated_tail", int'(data_o), 0);

        // Asynchronous reset mid-step.
        repeat (19) tick(0, 1, e);
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            tick(1, 1, e);
            if (e >= 100) reached = 1'b1;
        end
        check("mid_step_reached", int'(reached), 1);
        #1 rst = 1'b0;
        #1 check("async_reset", int'(data_o), 0);
        model_clear();
        #2 rst = 1'b1;
        tick(1, 1, e);
        tick(1, 1, e);
        check("restart_wait", int'(data_o), 0);
        tick(1, 1, e);
        check("restart_first", int'(data_o), -1);
        tick(1, 1, e);
        check("restart_second", int'(data_o), -4);

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            tick(int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 3) != 0) ? 1 : 0, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
